scan_mux: RTL

Parametrised, registered N:1 multiplexer. It selects one of CHANNELS input words either by an external select (manual mode) or by an internal round-robin scanner that dwells a fixed number of cycles per channel (auto mode). It succeeds the fixed 4:1 combinational mux and serves as the channel-scanning front end for display and serial-out blocks.

---
 rtl/scan_mux_pkg.sv | 13 +
 rtl/scan_mux_next_ch.sv | 65 ++++++
 rtl/scan_mux.sv | 95 +++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared state encoding and default sizing for scan_mux
package scan_mux_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } scan_state_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 1;
    localparam int DEF_DWELL    = 4;

endpackage

// File: rtl/scan_mux_next_ch.sv
// rtl/scan_mux_next_ch.sv - next-channel finder for the auto scan (SCAN_MUX_MASK_EN selects masked search)
module scan_mux_next_ch
    import scan_mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [SEL_W-1:0]    ptr,
    input  logic [CHANNELS-1:0] mask,
    output logic [SEL_W-1:0]    next_ptr,
    output logic                wrapped
);

`ifdef SCAN_MUX_MASK_EN
    // Pick the lowest enabled channel above ptr; failing that, the lowest
    // enabled channel at or below ptr, which is a wraparound. No enabled
    // channel at all leaves ptr where it is.
    always_comb begin
        int  base;
        int  hi;
        int  lo;
        logic hi_found;
        logic lo_found;
        next_ptr = ptr;
        wrapped  = 1'b0;
        hi       = 0;
        lo       = 0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        // An illegal ptr (only reachable from manual mode) behaves like the last channel.
        base = (int'(ptr) >= CHANNELS) ? CHANNELS - 1 : int'(ptr);
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (|(mask & (CHANNELS'(1) << k))) begin
                if (k > base) begin
                    hi_found = 1'b1;
                    hi       = k;
                end else begin
                    lo_found = 1'b1;
                    lo       = k;
                end
            end
        end
        if (hi_found) begin
            next_ptr = SEL_W'(hi);
        end else if (lo_found) begin
            next_ptr = SEL_W'(lo);
            wrapped  = (lo < base);
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^mask;

    // Plain increment modulo CHANNELS; an illegal ptr also returns to channel 0.
    always_comb begin
        next_ptr = ptr + SEL_W'(1);
        wrapped  = 1'b0;
        if (int'(ptr) >= CHANNELS - 1) begin
            next_ptr = '0;
            wrapped  = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N:1 mux with manual select or round-robin auto scan (option: SCAN_MUX_MASK_EN)
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DWELL    = DEF_DWELL,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto,
    input  logic                      hold,
    input  logic [CHANNELS-1:0]       mask,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      valid,
    output logic                      wrap
);

    localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    scan_state_t      state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] next_ptr;
    logic             next_wrap;
    logic [WIDTH-1:0] word;
    logic             enabled;
    logic             ok;

    scan_mux_next_ch #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next_ch (
        .ptr      (ptr),
        .mask     (mask),
        .next_ptr (next_ptr),
        .wrapped  (next_wrap)
    );

    // Channel word addressed by ptr; zero when ptr is past the last channel.
    always_comb begin
        word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(ptr) == k) begin
                word = WIDTH'(data_in >> (k * WIDTH));
            end
        end
    end

`ifdef SCAN_MUX_MASK_EN
    assign enabled = |(mask & (CHANNELS'(1) << ptr));
`else
    assign enabled = 1'b1;
`endif

    assign ok = (int'(ptr) < CHANNELS) && enabled;

    // Mode FSM, pointer/dwell state and the registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MANUAL;
            ptr      <= '0;
            cnt      <= '0;
            data_out <= '0;
            sel_out  <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state <= auto ? AUTO : MANUAL;
            wrap  <= 1'b0;
            if (!hold) begin
                if (state == MANUAL || !auto) begin
                    // Manual tracking, and the first cycle back from auto, load sel.
                    ptr <= sel;
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    ptr  <= next_ptr;
                    wrap <= next_wrap;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            data_out <= ok ? word : '0;
            sel_out  <= ptr;
            valid    <= ok;
        end
    end

endmodule
